rom_arbiter: RTL and testbench



---
 rtl/rom_arbiter_pkg.sv | 20 ++
 rtl/rom_arbiter_xlate.sv | 29 ++
 rtl/rom_arbiter.sv | 140 ++++++++++++++
 tb/tb_rom_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rom_arbiter_pkg
// Shared constants for the instruction-ROM arbiter: owner encoding carried
// down the pipeline, and the CPU/ROM geometry defaults (PC reset index, PC
// width, instruction width, ROM depth and index width).
// -----------------------------------------------------------------------------
package rom_arbiter_pkg;

  // Owner tag carried with every in-flight entry.
  localparam logic ARB_OWN_IF = 1'b0;  // instruction fetch (port 0)
  localparam logic ARB_OWN_LS = 1'b1;  // data-side read   (port 1)

  // CPU / ROM geometry defaults.
  localparam int                CPU_PC_SIZE     = 64;
  localparam int                CPU_INSTR_SIZE  = 32;
  localparam int                ROM_DATA_NUM    = 64;
  localparam int                ROM_DATA_IDXLEN = 6;
  localparam logic [63:0]       CPU_PC_RST_IDX  = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/rom_arbiter_xlate.sv
// -----------------------------------------------------------------------------
// rom_addr_xlate
// Combinational byte address -> ROM word index translation with error flag.
//   i_addr : byte address (IDX_LEN)
//   o_idx  : ROM word index (ROM_IDXLEN)
//   o_err  : 1 when the address is not word aligned or lies past the ROM
// The offset from BASE_IDX wraps at IDX_LEN bits, so addresses below the
// base become huge offsets and are flagged out of range.
// -----------------------------------------------------------------------------
module rom_addr_xlate #(
  parameter int                 IDX_LEN    = 64,
  parameter logic [IDX_LEN-1:0] BASE_IDX   = '0,
  parameter int                 ROM_NUM    = 64,
  parameter int                 ROM_IDXLEN = 6
) (
  input  logic [IDX_LEN-1:0]    i_addr,
  output logic [ROM_IDXLEN-1:0] o_idx,
  output logic                  o_err
);

  logic [IDX_LEN-1:0] w_off;
  logic [IDX_LEN-1:0] w_word;

  assign w_off  = i_addr - BASE_IDX;
  assign w_word = w_off >> 2;
  assign o_idx  = w_off[ROM_IDXLEN+1:2];
  assign o_err  = (w_off[1:0] != 2'b00) || (w_word >= IDX_LEN'(ROM_NUM));

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares the single-port instruction ROM between the fetch stage (port 0) and
// the data-side read path (port 1). Three stages:
//   A grant  : request accepted on valid & ready
//   B access : rom_idx_o registered, rom_data_i read combinationally
//   C resp   : registered response, held until the owner port accepts it
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid_i/_ready_o/_addr_i   request channel (byte address)
//   rsp{0,1}_valid_o/_ready_i/_data_o/_err_o   response channel
//   flush0_i                 drops all in-flight port-0 responses
//   rom_idx_o, rom_data_i    external ROM array interface
// Build option: define ROM_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with port 0 winning.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Requests: ready depends on valid (it is only raised for the winning
// port). Responses: valid, data and err stay stable until ready is seen.
// -----------------------------------------------------------------------------
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int                 IDX_LEN    = CPU_PC_SIZE,
  parameter logic [IDX_LEN-1:0] BASE_IDX   = IDX_LEN'(CPU_PC_RST_IDX),
  parameter int                 DATA_LEN   = CPU_INSTR_SIZE,
  parameter int                 ROM_NUM    = ROM_DATA_NUM,
  parameter int                 ROM_IDXLEN = ROM_DATA_IDXLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [IDX_LEN-1:0]    req0_addr_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [DATA_LEN-1:0]   rsp0_data_o,
  output logic                  rsp0_err_o,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [IDX_LEN-1:0]    req1_addr_i,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [DATA_LEN-1:0]   rsp1_data_o,
  output logic                  rsp1_err_o,
  input  logic                  flush0_i,
  output logic [ROM_IDXLEN-1:0] rom_idx_o,
  input  logic [DATA_LEN-1:0]   rom_data_i
);

  logic [ROM_IDXLEN-1:0] w_idx0, w_idx1, w_gnt_idx;
  logic                  w_err0, w_err1, w_gnt_err;
  logic                  w_pick1, w_gnt0, w_gnt1, w_gnt, w_gnt_own;
  logic                  w_c_ready, w_stall;

  // Stage B / C registers: valid, owner, error, and C data.
  logic                  r_vb, r_ob, r_eb;
  logic                  r_vc, r_oc, r_ec;
  logic [DATA_LEN-1:0]   r_data_c;
  logic [ROM_IDXLEN-1:0] r_rom_idx;

  rom_addr_xlate #(
    .IDX_LEN(IDX_LEN), .BASE_IDX(BASE_IDX), .ROM_NUM(ROM_NUM), .ROM_IDXLEN(ROM_IDXLEN)
  ) u_xlate0 (
    .i_addr(req0_addr_i), .o_idx(w_idx0), .o_err(w_err0)
  );

  rom_addr_xlate #(
    .IDX_LEN(IDX_LEN), .BASE_IDX(BASE_IDX), .ROM_NUM(ROM_NUM), .ROM_IDXLEN(ROM_IDXLEN)
  ) u_xlate1 (
    .i_addr(req1_addr_i), .o_idx(w_idx1), .o_err(w_err1)
  );

  // A held response stalls the pipe, unless it is a port-0 entry being
  // flushed this edge: then it disappears and the slot is free again.
  assign w_c_ready = (r_oc == ARB_OWN_IF) ? rsp0_ready_i : rsp1_ready_i;
  assign w_stall   = r_vc && !w_c_ready && !(flush0_i && (r_oc == ARB_OWN_IF));

`ifdef ROM_ARB_RR_EN
  // r_prio names the port that wins when both are valid.
  logic r_prio;
  assign w_pick1 = req1_valid_i && (!req0_valid_i || (r_prio == ARB_OWN_LS));
`else
  assign w_pick1 = req1_valid_i && !req0_valid_i;
`endif

  assign w_gnt0    = !rst && !w_stall && req0_valid_i && !w_pick1;
  assign w_gnt1    = !rst && !w_stall && w_pick1;
  assign w_gnt     = w_gnt0 || w_gnt1;
  assign w_gnt_own = w_gnt1 ? ARB_OWN_LS : ARB_OWN_IF;
  assign w_gnt_err = w_gnt1 ? w_err1 : w_err0;
  assign w_gnt_idx = w_gnt1 ? w_idx1 : w_idx0;

  assign req0_ready_o = w_gnt0;
  assign req1_ready_o = w_gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vb      <= 1'b0;
      r_ob      <= ARB_OWN_IF;
      r_eb      <= 1'b0;
      r_vc      <= 1'b0;
      r_oc      <= ARB_OWN_IF;
      r_ec      <= 1'b0;
      r_data_c  <= '0;
      r_rom_idx <= '0;
    end else if (!w_stall) begin
      // B moves into C (killed if it is a flushed fetch), A moves into B.
      r_vc     <= r_vb && !(flush0_i && (r_ob == ARB_OWN_IF));
      r_oc     <= r_ob;
      r_ec     <= r_eb;
      r_data_c <= r_eb ? '0 : rom_data_i;
      r_vb     <= w_gnt;
      r_ob     <= w_gnt_own;
      r_eb     <= w_gnt_err;
      // Errored requests leave the ROM index alone; their data is forced to 0.
      if (w_gnt && !w_gnt_err) r_rom_idx <= w_gnt_idx;
    end else begin
      // Stalled: everything holds, but a flush still removes a fetch in B.
      // A port-0 entry in C cannot be here while flushing (no stall then).
      if (flush0_i && (r_ob == ARB_OWN_IF)) r_vb <= 1'b0;
    end
  end

`ifdef ROM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (rst)        r_prio <= ARB_OWN_IF;
    else if (w_gnt) r_prio <= w_gnt1 ? ARB_OWN_IF : ARB_OWN_LS;
  end
`endif

  assign rom_idx_o    = r_rom_idx;
  assign rsp0_valid_o = r_vc && (r_oc == ARB_OWN_IF);
  assign rsp1_valid_o = r_vc && (r_oc == ARB_OWN_LS);
  assign rsp0_data_o  = rsp0_valid_o ? r_data_c : '0;
  assign rsp1_data_o  = rsp1_valid_o ? r_data_c : '0;
  assign rsp0_err_o   = rsp0_valid_o && r_ec;
  assign rsp1_err_o   = rsp1_valid_o && r_ec;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
// Directed bench for rom_arbiter. A bookkeeping process pushes the expected
// {err,data} of every accepted request into a per-port queue; a monitor pops
// and compares whenever a response is presented. Directed checks cover reset,
// latency, arbitration, address errors, backpressure, flush and mid-run reset.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  localparam int          IDX_LEN = CPU_PC_SIZE;
  localparam int          DLEN    = CPU_INSTR_SIZE;
  localparam int          RNUM    = ROM_DATA_NUM;
  localparam int          RIDX    = ROM_DATA_IDXLEN;
  localparam logic [63:0] BASE    = CPU_PC_RST_IDX;

  logic               clk, rst;
  logic               req0_valid_i, req0_ready_o, rsp0_valid_o, rsp0_ready_i, rsp0_err_o;
  logic               req1_valid_i, req1_ready_o, rsp1_valid_o, rsp1_ready_i, rsp1_err_o;
  logic [IDX_LEN-1:0] req0_addr_i, req1_addr_i;
  logic [DLEN-1:0]    rsp0_data_o, rsp1_data_o, rom_data_i;
  logic               flush0_i;
  logic [RIDX-1:0]    rom_idx_o;

  logic [DLEN:0] exp0_q[$];
  logic [DLEN:0] exp1_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  rom_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_data_o(rsp0_data_o),
    .rsp0_err_o(rsp0_err_o),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_data_o(rsp1_data_o),
    .rsp1_err_o(rsp1_err_o),
    .flush0_i(flush0_i), .rom_idx_o(rom_idx_o), .rom_data_i(rom_data_i)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- ROM model ----------------
  function automatic logic [DLEN-1:0] rom_word(input logic [RIDX-1:0] i);
    return {16'hC0DE, 2'b00, i, 2'b11, ~i};
  endfunction

  assign rom_data_i = rom_word(rom_idx_o);

  function automatic logic [DLEN:0] expect_rsp(input logic [63:0] addr);
    logic [63:0]     off;
    logic [RIDX-1:0] idx;
    off = addr - BASE;
    idx = off[RIDX+1:2];
    if (off[1:0] != 2'b00 || off >= 64'(RNUM) * 64'd4) return {1'b1, {DLEN{1'b0}}};
    return {1'b0, rom_word(idx)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- scoreboard push ----------------
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      if (flush0_i) exp0_q.delete();
      if (req0_valid_i && req0_ready_o) exp0_q.push_back(expect_rsp(req0_addr_i));
      if (req1_valid_i && req1_ready_o) exp1_q.push_back(expect_rsp(req1_addr_i));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rsp0_valid_o) begin
      if (exp0_q.size() == 0) check("rsp0_unexpected", rsp0_valid_o, 0);
      else begin
        check("rsp0_data", {rsp0_err_o, rsp0_data_o}, exp0_q[0]);
        if (rsp0_ready_i) void'(exp0_q.pop_front());
      end
    end
    if (rsp1_valid_o) begin
      if (exp1_q.size() == 0) check("rsp1_unexpected", rsp1_valid_o, 0);
      else begin
        check("rsp1_data", {rsp1_err_o, rsp1_data_o}, exp1_q[0]);
        if (rsp1_ready_i) void'(exp1_q.pop_front());
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Keeps pending requests up until each is accepted (bounded).
  task automatic drain_reqs(input string name, output logic first_any);
    logic a0, a1;
    first_any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!req0_valid_i && !req1_valid_i) break;
      @(negedge clk);
      a0 = req0_valid_i && req0_ready_o;
      a1 = req1_valid_i && req1_ready_o;
      if (i == 0) first_any = a0 || a1;
      tick();
      if (a0) req0_valid_i = 1'b0;
      if (a1) req1_valid_i = 1'b0;
    end
    check(name, {req0_valid_i, req1_valid_i}, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [63:0] t3_addr[5];
  logic        t3_err[5];
  logic        prev, any;

  initial begin
    rst = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_addr_i = '0; req1_addr_i = '0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    flush0_i = 1'b0;

    // Reset: ready held low even with requests present.
    tick(); tick();
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    @(negedge clk);
    check("rst_ready0", req0_ready_o, 0);
    check("rst_ready1", req1_ready_o, 0);
    check("rst_rsp0_valid", rsp0_valid_o, 0);
    check("rst_rsp1_valid", rsp1_valid_o, 0);
    check("rst_rom_idx", rom_idx_o, 0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();
    rst = 1'b0;
    rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    tick();

    // T1: streaming fetch of BASE+8, two-cycle latency.
    req0_addr_i = BASE + 64'd8; req0_valid_i = 1'b1;
    @(negedge clk);
    check("t1_ready0", req0_ready_o, 1);
    tick();
    @(negedge clk);
    check("t1_lat1_valid", rsp0_valid_o, 0);
    check("t1_rom_idx", rom_idx_o, 2);
    tick();
    @(negedge clk);
    check("t1_lat2_valid", rsp0_valid_o, 1);
    check("t1_data", {rsp0_err_o, rsp0_data_o}, {1'b0, 32'hC0DE_02FD});
    repeat (4) tick();
    req0_valid_i = 1'b0;
    repeat (3) tick();

    // T2: both ports valid.
    req0_addr_i = BASE; req1_addr_i = BASE + 64'd4;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef ROM_ARB_RR_EN
      check("t2_one_grant", req0_ready_o ^ req1_ready_o, 1);
      if (i > 0) check("t2_alternate", req0_ready_o, !prev);
      prev = req0_ready_o;
`else
      check("t2_ready0", req0_ready_o, 1);
      check("t2_ready1", req1_ready_o, 0);
`endif
      tick();
    end
    req0_valid_i = 1'b0;
    drain_reqs("t2_drain", any);
    repeat (3) tick();

    // T3: port-1 address error vectors.
    t3_addr[0] = BASE + 64'd2;             t3_err[0] = 1'b1;
    t3_addr[1] = BASE + 64'(RNUM) * 64'd4; t3_err[1] = 1'b1;
    t3_addr[2] = BASE - 64'd4;             t3_err[2] = 1'b1;
    t3_addr[3] = BASE + 64'(RNUM - 1) * 64'd4; t3_err[3] = 1'b0;
    t3_addr[4] = BASE + 64'd20;            t3_err[4] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        req1_addr_i = t3_addr[i]; req1_valid_i = 1'b1;
      end else begin
        req1_valid_i = 1'b0;
      end
      @(negedge clk);
      if (i < 5) check("t3_ready1", req1_ready_o, 1);
      if (i >= 2) begin
        check("t3_valid", rsp1_valid_o, 1);
        check("t3_err", rsp1_err_o, t3_err[i-2]);
        if (t3_err[i-2]) check("t3_err_data", rsp1_data_o, 0);
      end
      tick();
    end
    repeat (3) tick();

    // T4: backpressure on port 0.
    rsp0_ready_i = 1'b0;
    req0_addr_i = BASE + 64'd16; req0_valid_i = 1'b1;
    @(negedge clk);
    check("t4_ready0_a", req0_ready_o, 1);
    tick();
    req0_addr_i = BASE + 64'd20;
    @(negedge clk);
    check("t4_ready0_b", req0_ready_o, 1);
    tick();
    req0_addr_i = BASE + 64'd24;
    req1_addr_i = BASE + 64'd28; req1_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_stall_ready0", req0_ready_o, 0);
      check("t4_stall_ready1", req1_ready_o, 0);
      check("t4_hold", {rsp0_valid_o, rsp0_data_o}, {1'b1, 32'hC0DE_04FB});
      tick();
    end
    rsp0_ready_i = 1'b1;
    drain_reqs("t4_drain", any);
    check("t4_release_grant", any, 1);
    repeat (5) tick();

    // T5a: flush with two stale fetches in B/C and redirect to BASE+12.
    rsp0_ready_i = 1'b0;
    req0_addr_i = BASE; req0_valid_i = 1'b1;
    @(negedge clk);
    check("t5_ready0_a", req0_ready_o, 1);
    tick();
    req0_addr_i = BASE + 64'd4;
    @(negedge clk);
    check("t5_ready0_b", req0_ready_o, 1);
    tick();
    req0_addr_i = BASE + 64'd12; flush0_i = 1'b1;
    @(negedge clk);
    check("t5_redirect_ready", req0_ready_o, 1);
    tick();
    flush0_i = 1'b0; req0_valid_i = 1'b0; rsp0_ready_i = 1'b1;
    @(negedge clk);
    check("t5_killed", rsp0_valid_o, 0);
    tick();
    @(negedge clk);
    check("t5_redirect_rsp", {rsp0_valid_o, rsp0_err_o, rsp0_data_o}, {2'b10, 32'hC0DE_03FC});
    repeat (3) tick();

    // T5b: port-1 entry survives a fetch flush.
    rsp0_ready_i = 1'b0;
    req0_addr_i = BASE; req0_valid_i = 1'b1;
    @(negedge clk);
    check("t5_ready0_c", req0_ready_o, 1);
    tick();
    req0_valid_i = 1'b0;
    req1_addr_i = BASE + 64'd8; req1_valid_i = 1'b1;
    @(negedge clk);
    check("t5_ready1", req1_ready_o, 1);
    tick();
    req1_valid_i = 1'b0; flush0_i = 1'b1;
    tick();
    flush0_i = 1'b0;
    @(negedge clk);
    check("t5_port1_kept", {rsp1_valid_o, rsp1_err_o, rsp1_data_o}, {2'b10, 32'hC0DE_02FD});
    check("t5_port0_gone", rsp0_valid_o, 0);
    rsp0_ready_i = 1'b1;
    repeat (3) tick();

    // T6: reset with entries in B and C.
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    req0_addr_i = BASE + 64'd4; req0_valid_i = 1'b1;
    tick();
    req0_addr_i = BASE + 64'd8;
    tick();
    req0_valid_i = 1'b0; rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_rsp0_valid", rsp0_valid_o, 0);
    check("t6_rsp1_valid", rsp1_valid_o, 0);
    check("t6_rom_idx", rom_idx_o, 0);
    tick();
    rst = 1'b0; rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_quiet0", rsp0_valid_o, 0);
      check("t6_quiet1", rsp1_valid_o, 0);
      tick();
    end

    check("exp0_q_empty", exp0_q.size(), 0);
    check("exp1_q_empty", exp1_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
